// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types, constants and hazard helper for the pipeline controller
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALTED   = 2'd2
   } state_e;

   localparam logic [3:0] REG_ZERO = 4'h0;
   localparam int         WAIT_W   = 16;

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   function automatic logic load_use(input logic       memread,
                                     input logic [3:0] rd,
                                     input logic [3:0] rs,
                                     input logic [3:0] rt,
                                     input logic       uses_rt);
      return memread && (rd != REG_ZERO) && ((rd == rs) || (uses_rt && (rd == rt)));
   endfunction

endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit saturating event counter with sync active-low clear
module sat_counter16 (
   input  logic        clk_i,
   input  logic        clr_ni,
   input  logic        en_i,
   output logic [15:0] count_o
);

   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (en_i && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!clr_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/halt controller for a five-stage pipeline
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        idex_memread,
   input  logic [3:0]  idex_rd,
   input  logic [3:0]  ifid_rs,
   input  logic [3:0]  ifid_rt,
   input  logic        ifid_uses_rt,
   input  logic        branch_taken,
   input  logic        mem_req,
   input  logic        mem_ready,
   input  logic        hlt_wb,
   output logic        pc_wen,
   output logic        ifid_stall,
   output logic        idex_stall,
   output logic        exm_stall,
   output logic        mwb_stall,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        halted,
   output logic        mem_timeout,
   output logic [15:0] stall_cycles
);

   localparam logic [WAIT_W:0] TMO_LIM = (WAIT_W + 1)'(MEM_TIMEOUT);

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [WAIT_W:0]     wait_inc;
   logic                timeout_q, timeout_d;
   logic                mem_stall;
   logic                hazard;

   assign wait_inc = {1'b0, wait_q} + 1'b1;
   assign hazard   = load_use(idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt);

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      timeout_d  = timeout_q;
      mem_stall  = 1'b0;
      pc_wen     = 1'b1;
      ifid_stall = 1'b0;
      idex_stall = 1'b0;
      exm_stall  = 1'b0;
      mwb_stall  = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      halted     = 1'b0;

      case (state_q)
         RUN: begin
            mem_stall = mem_req && !mem_ready;
            wait_d    = '0;
            if (hlt_wb) begin
               state_d = HALTED;
            end else if (mem_stall) begin
               state_d = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            mem_stall = !mem_ready;
            if (mem_ready) begin
               state_d = RUN;
               wait_d  = '0;
            end else if (wait_inc >= TMO_LIM) begin
               // Give up on the access so the core is not wedged forever.
               state_d   = RUN;
               wait_d    = '0;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_inc[WAIT_W-1:0];
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      if (!rst || (state_q == HALTED) || mem_stall) begin
         pc_wen     = 1'b0;
         ifid_stall = 1'b1;
         idex_stall = 1'b1;
         exm_stall  = 1'b1;
         mwb_stall  = 1'b1;
         halted     = rst && (state_q == HALTED);
      end else if (hazard) begin
         pc_wen     = 1'b0;
         ifid_stall = 1'b1;
         idex_flush = 1'b1;
      end else if (branch_taken) begin
         ifid_flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   assign mem_timeout = timeout_q;

   sat_counter16 u_stall_cnt (
      .clk_i   (clk),
      .clr_ni  (rst),
      .en_i    (rst && !pc_wen && (state_q != HALTED)),
      .count_o (stall_cycles)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl with directed vectors
module tb_pipeline_ctrl;

   typedef struct packed {
      logic       rst;
      logic       memread;
      logic [3:0] rd;
      logic [3:0] rs;
      logic [3:0] rt;
      logic       uses_rt;
      logic       br;
      logic       req;
      logic       rdy;
      logic       hlt;
   } in_t;

   // stl = {ifid, idex, exm, mwb}, fl = {ifid_flush, idex_flush}
   typedef struct packed {
      logic        pc;
      logic [3:0]  stl;
      logic [1:0]  fl;
      logic        h;
      logic        tmo;
      logic [15:0] cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        idex_memread = 1'b0;
   logic [3:0]  idex_rd = 4'h0;
   logic [3:0]  ifid_rs = 4'h0;
   logic [3:0]  ifid_rt = 4'h0;
   logic        ifid_uses_rt = 1'b0;
   logic        branch_taken = 1'b0;
   logic        mem_req = 1'b0;
   logic        mem_ready = 1'b0;
   logic        hlt_wb = 1'b0;
   logic        pc_wen, ifid_stall, idex_stall, exm_stall, mwb_stall;
   logic        ifid_flush, idex_flush, halted, mem_timeout;
   logic [15:0] stall_cycles;

   int    checks = 0;
   int    errors = 0;
   exp_t  exp_q[$];
   string name_q[$];

   always #5 clk = ~clk;

   pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .idex_memread (idex_memread),
      .idex_rd      (idex_rd),
      .ifid_rs      (ifid_rs),
      .ifid_rt      (ifid_rt),
      .ifid_uses_rt (ifid_uses_rt),
      .branch_taken (branch_taken),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .hlt_wb       (hlt_wb),
      .pc_wen       (pc_wen),
      .ifid_stall   (ifid_stall),
      .idex_stall   (idex_stall),
      .exm_stall    (exm_stall),
      .mwb_stall    (mwb_stall),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .halted       (halted),
      .mem_timeout  (mem_timeout),
      .stall_cycles (stall_cycles)
   );

   function automatic in_t mkin(input logic r, input logic mr, input logic [3:0] rd,
                                input logic [3:0] rs, input logic [3:0] rt, input logic ut,
                                input logic br, input logic rq, input logic ry, input logic hl);
      in_t v;
      v = '{rst: r, memread: mr, rd: rd, rs: rs, rt: rt, uses_rt: ut,
            br: br, req: rq, rdy: ry, hlt: hl};
      return v;
   endfunction

   function automatic exp_t mkexp(input logic pc, input logic [3:0] stl, input logic [1:0] fl,
                                  input logic h, input logic tmo, input logic [15:0] cyc);
      exp_t e;
      e = '{pc: pc, stl: stl, fl: fl, h: h, tmo: tmo, cyc: cyc};
      return e;
   endfunction

   task automatic apply(input string n, input in_t v, input exp_t e);
      @(posedge clk);
      #1;
      rst          = v.rst;
      idex_memread = v.memread;
      idex_rd      = v.rd;
      ifid_rs      = v.rs;
      ifid_rt      = v.rt;
      ifid_uses_rt = v.uses_rt;
      branch_taken = v.br;
      mem_req      = v.req;
      mem_ready    = v.rdy;
      hlt_wb       = v.hlt;
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   task automatic chk(input string n, input string f, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s: got %h expected %h", n, f, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t  e;
         string n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         chk(n, "pc_wen", 16'(pc_wen), 16'(e.pc));
         chk(n, "stalls", 16'({ifid_stall, idex_stall, exm_stall, mwb_stall}), 16'(e.stl));
         chk(n, "flushes", 16'({ifid_flush, idex_flush}), 16'(e.fl));
         chk(n, "halted", 16'(halted), 16'(e.h));
         chk(n, "mem_timeout", 16'(mem_timeout), 16'(e.tmo));
         chk(n, "stall_cycles", stall_cycles, e.cyc);
      end
   end

   initial begin
      in_t idle;
      idle = mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);

      apply("reset",       mkin(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0), mkexp(0, 4'hF, 2'b00, 0, 0, 0));
      apply("idle",        idle,                                      mkexp(1, 4'h0, 2'b00, 0, 0, 0));
      apply("lu_rs",       mkin(1, 1, 4'h3, 4'h3, 4'h0, 0, 0, 0, 0, 0), mkexp(0, 4'h8, 2'b01, 0, 0, 0));
      apply("after_lu",    idle,                                      mkexp(1, 4'h0, 2'b00, 0, 0, 1));
      apply("lu_r0",       mkin(1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0), mkexp(1, 4'h0, 2'b00, 0, 0, 1));
      apply("lu_rt",       mkin(1, 1, 4'h5, 4'h1, 4'h5, 1, 0, 0, 0, 0), mkexp(0, 4'h8, 2'b01, 0, 0, 1));
      apply("rt_unused",   mkin(1, 1, 4'h5, 4'h1, 4'h5, 0, 0, 0, 0, 0), mkexp(1, 4'h0, 2'b00, 0, 0, 2));
      apply("branch",      mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 0, 0), mkexp(1, 4'h0, 2'b10, 0, 0, 2));
      apply("br_lu",       mkin(1, 1, 4'h3, 4'h3, 4'h0, 0, 1, 0, 0, 0), mkexp(0, 4'h8, 2'b01, 0, 0, 2));
      apply("idle2",       idle,                                      mkexp(1, 4'h0, 2'b00, 0, 0, 3));

      apply("mem_run",     mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0), mkexp(0, 4'hF, 2'b00, 0, 0, 3));
      apply("mem_w1",      mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0), mkexp(0, 4'hF, 2'b00, 0, 0, 4));
      apply("mem_w2",      mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0), mkexp(0, 4'hF, 2'b00, 0, 0, 5));
      apply("mem_rdy",     mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 1, 0), mkexp(1, 4'h0, 2'b00, 0, 0, 6));
      apply("mem_after",   idle,                                      mkexp(1, 4'h0, 2'b00, 0, 0, 6));
      apply("mem_over_lu", mkin(1, 1, 4'h3, 4'h3, 4'h0, 0, 1, 1, 0, 0), mkexp(0, 4'hF, 2'b00, 0, 0, 6));
      apply("mem_rdy2",    mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 1, 0), mkexp(1, 4'h0, 2'b00, 0, 0, 7));
      apply("mw_hlt_a",    mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0), mkexp(0, 4'hF, 2'b00, 0, 0, 7));
      apply("mw_hlt_b",    mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 1), mkexp(0, 4'hF, 2'b00, 0, 0, 8));
      apply("mw_hlt_c",    mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 1, 0), mkexp(1, 4'h0, 2'b00, 0, 0, 9));
      apply("mw_hlt_d",    idle,                                      mkexp(1, 4'h0, 2'b00, 0, 0, 9));

      apply("hlt_run",     mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 1), mkexp(1, 4'h0, 2'b00, 0, 0, 9));
      for (int k = 0; k < 10; k++) begin
         apply($sformatf("halted%0d", k), mkin(1, 1, 4'h3, 4'h3, 4'h0, 0, 1, 0, 0, 0),
               mkexp(0, 4'hF, 2'b00, 1, 0, 9));
      end
      apply("hlt_rst",     mkin(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0), mkexp(0, 4'hF, 2'b00, 0, 0, 9));
      apply("hlt_run2",    idle,                                      mkexp(1, 4'h0, 2'b00, 0, 0, 0));

      apply("tmo_run",     mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0), mkexp(0, 4'hF, 2'b00, 0, 0, 0));
      for (int k = 0; k < 4; k++) begin
         apply($sformatf("tmo_w%0d", k + 1), mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0),
               mkexp(0, 4'hF, 2'b00, 0, 0, 16'(k + 1)));
      end
      apply("tmo_set",     idle,                                      mkexp(1, 4'h0, 2'b00, 0, 1, 5));
      apply("tmo_sticky",  idle,                                      mkexp(1, 4'h0, 2'b00, 0, 1, 5));
      apply("rmw_run",     mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0), mkexp(0, 4'hF, 2'b00, 0, 1, 5));
      apply("rmw_w1",      mkin(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0), mkexp(0, 4'hF, 2'b00, 0, 1, 6));
      apply("rmw_rst",     mkin(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0), mkexp(0, 4'hF, 2'b00, 0, 1, 7));
      apply("rmw_clear",   idle,                                      mkexp(1, 4'h0, 2'b00, 0, 0, 0));

      for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
         @(negedge clk);
      end
      @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-low reset; sampled on rising clk only.
REQ-003 SHALL have port: idex_memread  input  1  instruction in EX is a load.
REQ-004 SHALL have port: idex_rd  input  4  destination register of the instruction in EX.
REQ-005 SHALL have port: ifid_rs, ifid_rt  input  4 each  source registers of the instruction in ID.
REQ-006 SHALL have port: ifid_uses_rt  input  1  the ID instruction reads rt.
REQ-007 SHALL have port: branch_taken  input  1  branch resolved taken in ID this cycle.
REQ-008 SHALL have port: mem_req, mem_ready  input  1 each  MEM-stage data access pending / completes this cycle.
REQ-009 SHALL have port: hlt_wb  input  1  HLT instruction is in WB.
REQ-010 SHALL have port: pc_wen  output  1  PC write enable.
REQ-011 SHALL have port: ifid_stall, idex_stall, exm_stall, mwb_stall  output  1 each  stall_en to the four pipeline registers (1 = hold).
REQ-012 SHALL have port: ifid_flush, idex_flush  output  1 each  replace next register contents with a bubble (all control bits 0).
REQ-013 SHALL have port: halted  output  1  processor halted.
REQ-014 SHALL have port: mem_timeout  output  1  sticky error: memory wait exceeded limit.
REQ-015 SHALL have port: stall_cycles  output  16  count of cycles with pc_wen=0 while not halted.
REQ-016 SHALL have parameter: MEM_TIMEOUT, default 255, maximum consecutive MEM_WAIT cycles before timeout.

Function
REQ-017 SHALL implement FSM states RUN, MEM_WAIT, HALTED; all outputs are combinational from state and current inputs (zero-cycle stall latency).
REQ-018 SHALL, in RUN with mem_req=1 and mem_ready=0, assert all four stalls, deassert pc_wen, and enter MEM_WAIT on the next edge.
REQ-019 SHALL, in MEM_WAIT, hold all four stalls and pc_wen=0 until a cycle with mem_ready=1; that cycle releases all stalls and returns to RUN on the next edge.
REQ-020 SHALL detect load-use when idex_memread=1, idex_rd!=0, and (idex_rd==ifid_rs or (ifid_uses_rt and idex_rd==ifid_rt)).
REQ-021 SHALL, on load-use in RUN with no memory stall: pc_wen=0, ifid_stall=1, idex_flush=1, exm_stall=mwb_stall=0; exactly one bubble per hazard.
REQ-022 SHALL, on branch_taken in RUN with no load-use and no memory stall, assert ifid_flush=1 with pc_wen=1.
REQ-023 SHALL give priority: HALTED > memory stall > load-use > branch flush; a suppressed branch_taken produces no flush (ID re-evaluates it).
REQ-024 SHALL, on hlt_wb=1 in RUN, enter HALTED next edge; in HALTED all stalls=1, pc_wen=0, flushes=0, halted=1, until reset.
REQ-025 SHALL ignore hlt_wb while in MEM_WAIT; HALTED is entered only from RUN.
REQ-026 SHALL count consecutive MEM_WAIT cycles; on reaching MEM_TIMEOUT, set mem_timeout=1 (sticky until reset) and force return to RUN.
REQ-027 SHALL increment stall_cycles on every cycle with pc_wen=0 and state!=HALTED, saturating at 16'hFFFF (no wrap).
REQ-028 SHALL drive pc_wen=1 and all stalls/flushes=0 in RUN when no hazard, memory stall, or branch is present.

Reset
REQ-029 SHALL, when rst=0 at a rising edge, enter RUN and clear wait counter, mem_timeout, and stall_cycles to 0, regardless of current state, including mid-MEM_WAIT and HALTED.
REQ-030 SHALL, while rst=0, drive pc_wen=0, all stalls=1, flushes=0, halted=0.

Structure
REQ-031 SHALL place the state enum and REG_ZERO (4'h0) in shared package pipe_ctrl_pkg.
REQ-032 SHALL implement stall_cycles as sub-module sat_counter16 (enable, sync active-low clear, saturating).

Verification
REQ-033 SHALL test: idex_memread=1, idex_rd=3, ifid_rs=3 -> one cycle pc_wen=0, ifid_stall=1, idex_flush=1; stall_cycles=1.
REQ-034 SHALL test: idex_rd=0 with matching rs, load -> no stall, pc_wen=1.
REQ-035 SHALL test: mem_req=1, mem_ready low 3 cycles then high -> all stalls high 3 cycles, released on the 4th; stall_cycles=3.
REQ-036 SHALL test: branch_taken=1 with simultaneous load-use -> no ifid_flush, load-use bubble only.
REQ-037 SHALL test: hlt_wb=1 -> halted=1 next cycle, stays through 10 cycles; rst=0 -> RUN, halted=0.
REQ-038 SHALL test: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after 4 wait cycles, state RUN; rst=0 mid-MEM_WAIT clears everything.
